// File: rtl/quad_steer_pkg.sv
// quad_steer_pkg: shared phase, direction types and Gray-sequence helper for quad_steer_gen
package quad_steer_pkg;
    typedef logic [1:0] phase_t;
    typedef enum logic [1:0] {DIR_IDLE, DIR_CW, DIR_CCW} dir_t;
    localparam phase_t PH0 = 2'b00;
    localparam phase_t PH1 = 2'b01;
    localparam phase_t PH2 = 2'b11;
    localparam phase_t PH3 = 2'b10;
    function automatic phase_t next_phase(input phase_t p, input logic cw);
        return cw ? {p[0], ~p[1]} : {~p[0], p[1]};
    endfunction
endpackage

// File: rtl/quad_steer_chan.sv
// quad_steer_chan: one steering channel with period counter, acceleration and Gray phase
module quad_steer_chan
    import quad_steer_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int ACCEL_HOLD = 8,
    parameter int ACCEL_MAX  = 3
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic [DIV_W-1:0] clkdiv,
    input  logic             accel_en,
    input  logic             left,
    input  logic             right,
    output logic [1:0]       steer,
    output logic             step,
    output logic [1:0]       level
);
    localparam int HW = $clog2(ACCEL_HOLD + 1);
    phase_t           phase_q, phase_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, cnt_b, shifted, eff;
    logic [1:0]       lvl_q, lvl_d, lvl_b;
    logic [HW-1:0]    hold_q, hold_d, hold_b;
    dir_t             dir, last_dir_q;
    logic             step_q, step_d, restart, hit, bump;
    always_comb begin
        dir     = (right && !left) ? DIR_CW : (left && !right) ? DIR_CCW : DIR_IDLE;
        restart = dir == DIR_IDLE || dir != last_dir_q;
        cnt_b   = restart ? '0 : cnt_q;
        lvl_b   = restart ? '0 : lvl_q;
        hold_b  = restart ? '0 : hold_q;
        shifted = accel_en ? clkdiv >> lvl_b : clkdiv;
        eff     = (shifted == '0 && clkdiv != '0) ? DIV_W'(1) : shifted;
        hit     = dir != DIR_IDLE && eff != '0 && cnt_b == eff - DIV_W'(1);
        bump    = hit && accel_en && hold_b == HW'(ACCEL_HOLD - 1);
        cnt_d   = (dir == DIR_IDLE || eff == '0 || hit) ? '0 : cnt_b + DIV_W'(1);
        phase_d = hit ? next_phase(phase_q, dir == DIR_CW) : phase_q;
        step_d  = hit;
        hold_d  = (!accel_en || bump) ? '0 : hit ? hold_b + HW'(1) : hold_b;
        lvl_d   = !accel_en ? '0 : (bump && lvl_b < 2'(ACCEL_MAX)) ? lvl_b + 2'd1 : lvl_b;
    end
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            phase_q    <= PH0;
            cnt_q      <= '0;
            lvl_q      <= '0;
            hold_q     <= '0;
            step_q     <= 1'b0;
            last_dir_q <= DIR_IDLE;
        end else begin
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            lvl_q      <= lvl_d;
            hold_q     <= hold_d;
            step_q     <= step_d;
            last_dir_q <= dir;
        end
    end
    assign steer = phase_q;
    assign step  = step_q;
    assign level = lvl_q;
endmodule

// File: rtl/quad_steer_gen.sv
// quad_steer_gen: multi-channel held-button to quadrature steering generator
module quad_steer_gen
    import quad_steer_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int DIV_W      = 16,
    parameter int ACCEL_HOLD = 8,
    parameter int ACCEL_MAX  = 3
) (
    input  logic                  CLK,
    input  logic                  Reset_n,
    input  logic [DIV_W-1:0]      clkdiv,
    input  logic                  accel_en,
    input  logic [CHANNELS-1:0]   left,
    input  logic [CHANNELS-1:0]   right,
    output logic [2*CHANNELS-1:0] steer,
    output logic [CHANNELS-1:0]   step,
    output logic [2*CHANNELS-1:0] level
);
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        quad_steer_chan #(
            .DIV_W(DIV_W),
            .ACCEL_HOLD(ACCEL_HOLD),
            .ACCEL_MAX(ACCEL_MAX)
        ) u_chan (
            .CLK(CLK),
            .Reset_n(Reset_n),
            .clkdiv(clkdiv),
            .accel_en(accel_en),
            .left(left[c]),
            .right(right[c]),
            .steer(steer[2*c +: 2]),
            .step(step[c]),
            .level(level[2*c +: 2])
        );
    end
endmodule
